axilite_noc_request: RTL and testbench
======================================

# axilite_noc_request

Request-side half of the AXI-lite to NoC bridge. Accepts single-beat AXI-lite read (AR) and write (AW+W) requests and serialises each into a non-cacheable NoC request packet of 64-bit flits. For every accepted request it pushes a 6-bit transaction descriptor into the response side's type FIFO. The response side uses that descriptor to decode the returning NoC responses in order.

## Interface
Parameters:
- AXILITE_DATA_WIDTH, 64, AXI-lite data width; equals `NOC_DATA_WIDTH.
- AXILITE_ADDR_WIDTH, 64, AXI-lite address width; low `PHY_ADDR_WIDTH bits forwarded.
- MSG_TYPE_LOAD, 2'd1, descriptor flit_type for reads.
- MSG_TYPE_STORE, 2'd2, descriptor flit_type for writes.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- src_chipid/src_xpos/src_ypos/src_fbits  in  `NOC_CHIPID_WIDTH/`NOC_X_WIDTH/`NOC_Y_WIDTH/`NOC_FBITS_WIDTH  requester identity (header 2); quasi-static.
- dest_chipid/dest_xpos/dest_ypos/dest_fbits  in  same widths  target identity (header 0); quasi-static.
- s_axi_araddr  in  AXILITE_ADDR_WIDTH;  s_axi_arvalid in 1;  s_axi_arready out 1.
- s_axi_awaddr  in  AXILITE_ADDR_WIDTH;  s_axi_awvalid in 1;  s_axi_awready out 1.
- s_axi_wdata  in  64;  s_axi_wstrb  in  8;  s_axi_wvalid  in 1;  s_axi_wready  out 1.
- noc_valid_out  out  1;  noc_data_out  out  `NOC_DATA_WIDTH;  noc_ready_in  in  1.
- transaction_type_wr_data  out  6  descriptor {last_write_flit, last_read_transfer, read_size, read_word_select, flit_type[1:0]}.
- transaction_type_wr  out  1  one-cycle push strobe.
- transaction_type_full  in  1  type FIFO full.

## Operation
- FSM states: IDLE, HDR0, HDR1, HDR2, DATA.
- **IDLE, acceptance:**
  - A request is eligible only when transaction_type_full=0.
  - A read is eligible when arvalid=1.
  - A write is eligible when awvalid=1 and wvalid=1. AW and W are always accepted in the same cycle (awready=wready).
  - When both are eligible, the arbiter picks one (see Configuration).
- **Accept cycle:**
  - Assert the selected ready.
  - Capture address, data, strobe and the op into registers.
  - Pulse transaction_type_wr.
  - Move to HDR0.
- **Descriptors:**
  - Read: {0, 1, 0, araddr[3], MSG_TYPE_LOAD}.
  - Write: {1, 0, 0, 0, MSG_TYPE_STORE}.
- **HDR0 flit:**
  - Destination chipid/x/y/fbits.
  - `MSG_LENGTH = 2 for a load, 3 for a store.
  - `MSG_TYPE = `MSG_TYPE_NC_LOAD_REQ or `MSG_TYPE_NC_STORE_REQ.
  - `MSG_MSHRID = 0.
- **HDR1 flit:**
  - `MSG_ADDR = captured address.
  - `MSG_DATA_SIZE derived from wstrb:
    - 0xFF → 8B.
    - Aligned 0x0F/0xF0 → 4B.
    - Aligned 2-bit pairs → 2B.
    - One-hot → 1B.
    - Reads and any other strobe pattern → 8B.
  - For sub-8B stores, the address low bits are set to the offset of the lowest set strobe bit.
- **HDR2 flit:** source chipid/x/y/fbits.
- **DATA flit (stores only):** wdata byte-reversed (byte 0 to bits [63:56] … byte 7 to bits [7:0]).
- **Transitions** (each advances on noc_valid_out && noc_ready_in):
  - HDR0 → HDR1 → HDR2.
  - HDR2 → DATA for a store, → IDLE for a load.
  - DATA → IDLE.
- While not in IDLE: arready=awready=wready=0.

## Timing
- **Reset values:** state IDLE; noc_valid_out=0; noc_data_out=0; all readies 0; transaction_type_wr=0.
- **Readies:** combinational from state, valids and transaction_type_full. Asserted only in IDLE.
- **Latency:** HDR0 is valid the cycle after acceptance.
- **Throughput, no back-pressure:** a load takes 4 cycles (accept + 3 flits); a store takes 5.
- **noc_valid_out:** high in HDR0..DATA. Data is held stable while noc_ready_in=0.
- **Back-to-back:** IDLE accepts a new request the cycle after the last flit handshake. There are no bubbles inside a packet.
- **transaction_type_full=1 in IDLE:** no ready is asserted, and no push occurs even if valids are high.
- **Reset mid-packet:** the FSM returns to IDLE and the partial packet is abandoned. The system resets the NoC and response side together.

## Configuration
- AXILITE_NOC_REQ_RR_ARB_EN defined:
  - Round-robin between read and write. A 1-bit last-granted flop updates on each accept; reset value favours read first.
- AXILITE_NOC_REQ_RR_ARB_EN undefined:
  - Fixed priority, reads always win. The write waits while arvalid stays high.

## Test plan
- **Read:** araddr=0x8000_0008, noc_ready_in=1.
  - arready pulses once; descriptor 6'b010101 is pushed.
  - Flits: HDR0 with length 2 and NC_LOAD; HDR1 with addr 0x8000_0008, size 8B; HDR2 with source identity.
  - Returns to IDLE at cycle 4.
- **Full write:** awaddr=0x100, wdata=0x0123456789ABCDEF, wstrb=0xFF.
  - Descriptor 6'b100010.
  - 4 flits; length 3; DATA flit = 0xEFCDAB8967452301.
- **Partial write:** wstrb=0x30, awaddr=0x100.
  - HDR1 size 2B, address 0x104.
- **Back-pressure:** noc_ready_in held 0 for 5 cycles during HDR1.
  - HDR1 data stable throughout; no new accept; completes after ready returns.
- **Simultaneous AR and AW/W, 4 requests each:**
  - With RR_ARB_EN: grants alternate R,W,R,W…
  - Without: all 4 reads are granted first.
- **transaction_type_full=1 with arvalid=1:** no arready and no push. Deassert full → accept on the same cycle.

Source files
------------

// File: rtl/axilite_noc_request.sv
// axilite_noc_request: request half of the AXI-lite to NoC bridge.
// Turns each single-beat AXI-lite read (AR) or write (AW+W) into a
// non-cacheable NoC request packet of 64-bit flits: HDR0, HDR1, HDR2,
// plus one DATA flit for stores. For every accepted request it pushes a
// 6-bit descriptor into the response side's type FIFO.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   src_*/dest_*          requester (HDR2) / target (HDR0) identity
//   s_axi_ar*/aw*/w*      AXI-lite request channels (AW and W in lockstep)
//   noc_valid_out/noc_data_out/noc_ready_in   flit stream out
//   transaction_type_*    descriptor push side of the response type FIFO
// Build option: define AXILITE_NOC_REQ_RR_ARB_EN for round-robin
// read/write arbitration; without it reads have fixed priority.

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef NOC_CHIPID_WIDTH
`define NOC_CHIPID_WIDTH 14
`endif
`ifndef NOC_X_WIDTH
`define NOC_X_WIDTH 8
`endif
`ifndef NOC_Y_WIDTH
`define NOC_Y_WIDTH 8
`endif
`ifndef NOC_FBITS_WIDTH
`define NOC_FBITS_WIDTH 4
`endif
`ifndef PHY_ADDR_WIDTH
`define PHY_ADDR_WIDTH 40
`endif
`ifndef MSG_DST_CHIPID
`define MSG_DST_CHIPID 63:50
`define MSG_DST_X 49:42
`define MSG_DST_Y 41:34
`define MSG_DST_FBITS 33:30
`define MSG_LENGTH 29:22
`define MSG_TYPE 21:14
`define MSG_MSHRID 13:6
`endif
`ifndef MSG_ADDR
`define MSG_ADDR 63:16
`define MSG_ADDR_WIDTH 48
`define MSG_DATA_SIZE 15:13
`endif
`ifndef MSG_SRC_CHIPID
`define MSG_SRC_CHIPID 63:50
`define MSG_SRC_X 49:42
`define MSG_SRC_Y 41:34
`define MSG_SRC_FBITS 33:30
`endif
`ifndef MSG_TYPE_NC_LOAD_REQ
`define MSG_TYPE_NC_LOAD_REQ 8'd14
`define MSG_TYPE_NC_STORE_REQ 8'd15
`endif
`ifndef MSG_DATA_SIZE_1B
`define MSG_DATA_SIZE_1B 3'b001
`define MSG_DATA_SIZE_2B 3'b010
`define MSG_DATA_SIZE_4B 3'b011
`define MSG_DATA_SIZE_8B 3'b100
`endif

module axilite_noc_request #(
   parameter int         AXILITE_DATA_WIDTH = 64,
   parameter int         AXILITE_ADDR_WIDTH = 64,
   parameter logic [1:0] MSG_TYPE_LOAD      = 2'd1,
   parameter logic [1:0] MSG_TYPE_STORE     = 2'd2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [`NOC_CHIPID_WIDTH-1:0]     src_chipid,
   input  logic [`NOC_X_WIDTH-1:0]          src_xpos,
   input  logic [`NOC_Y_WIDTH-1:0]          src_ypos,
   input  logic [`NOC_FBITS_WIDTH-1:0]      src_fbits,
   input  logic [`NOC_CHIPID_WIDTH-1:0]     dest_chipid,
   input  logic [`NOC_X_WIDTH-1:0]          dest_xpos,
   input  logic [`NOC_Y_WIDTH-1:0]          dest_ypos,
   input  logic [`NOC_FBITS_WIDTH-1:0]      dest_fbits,
   input  logic [AXILITE_ADDR_WIDTH-1:0]    s_axi_araddr,
   input  logic                             s_axi_arvalid,
   output logic                             s_axi_arready,
   input  logic [AXILITE_ADDR_WIDTH-1:0]    s_axi_awaddr,
   input  logic                             s_axi_awvalid,
   output logic                             s_axi_awready,
   input  logic [AXILITE_DATA_WIDTH-1:0]    s_axi_wdata,
   input  logic [7:0]                       s_axi_wstrb,
   input  logic                             s_axi_wvalid,
   output logic                             s_axi_wready,
   output logic                             noc_valid_out,
   output logic [`NOC_DATA_WIDTH-1:0]       noc_data_out,
   input  logic                             noc_ready_in,
   output logic [5:0]                       transaction_type_wr_data,
   output logic                             transaction_type_wr,
   input  logic                             transaction_type_full
);

   localparam int PA = `PHY_ADDR_WIDTH;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR0 = 3'd1,
      HDR1 = 3'd2,
      HDR2 = 3'd3,
      DATA = 3'd4
   } state_e;

   state_e                        state_q, state_d;
   logic [PA-1:0]                 addr_q, addr_d;
   logic [AXILITE_DATA_WIDTH-1:0] data_q, data_d;
   logic [7:0]                    strb_q, strb_d;
   logic                          store_q, store_d;

   logic rd_elig, wr_elig;
   logic pick_rd, pick_wr;

   logic [2:0]    size_code;
   logic [2:0]    byte_off;
   logic          sub_dword;
   logic [PA-1:0] flit_addr;

   // Only the physical address bits travel on the NoC.
   logic unused_addr_hi;
   assign unused_addr_hi = ^{s_axi_araddr[AXILITE_ADDR_WIDTH-1:PA],
                             s_axi_awaddr[AXILITE_ADDR_WIDTH-1:PA]};

   assign rd_elig = s_axi_arvalid & ~transaction_type_full;
   assign wr_elig = s_axi_awvalid & s_axi_wvalid & ~transaction_type_full;

`ifdef AXILITE_NOC_REQ_RR_ARB_EN
   // last_wr_q=1 means the write was granted last, so reads go next.
   logic last_wr_q, last_wr_d;

   assign pick_rd = rd_elig & (~wr_elig | last_wr_q);

   always_comb begin
      last_wr_d = last_wr_q;
      if (state_q == IDLE) begin
         if (pick_rd) begin
            last_wr_d = 1'b0;
         end else if (pick_wr) begin
            last_wr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_wr_q <= 1'b1;
      end else begin
         last_wr_q <= last_wr_d;
      end
   end
`else
   assign pick_rd = rd_elig;
`endif

   assign pick_wr = wr_elig & ~pick_rd;

   // Next state, capture registers, readies and descriptor push.
   always_comb begin
      state_d                  = state_q;
      addr_d                   = addr_q;
      data_d                   = data_q;
      strb_d                   = strb_q;
      store_d                  = store_q;
      s_axi_arready            = 1'b0;
      s_axi_awready            = 1'b0;
      s_axi_wready             = 1'b0;
      transaction_type_wr      = 1'b0;
      transaction_type_wr_data = 6'd0;
      case (state_q)
         IDLE: begin
            if (pick_rd) begin
               s_axi_arready            = 1'b1;
               addr_d                   = s_axi_araddr[PA-1:0];
               strb_d                   = 8'hFF;
               store_d                  = 1'b0;
               transaction_type_wr      = 1'b1;
               transaction_type_wr_data = {1'b0, 1'b1, 1'b0,
                                           s_axi_araddr[3],
                                           MSG_TYPE_LOAD};
               state_d                  = HDR0;
            end else if (pick_wr) begin
               s_axi_awready            = 1'b1;
               s_axi_wready             = 1'b1;
               addr_d                   = s_axi_awaddr[PA-1:0];
               data_d                   = s_axi_wdata;
               strb_d                   = s_axi_wstrb;
               store_d                  = 1'b1;
               transaction_type_wr      = 1'b1;
               transaction_type_wr_data = {1'b1, 1'b0, 1'b0, 1'b0,
                                           MSG_TYPE_STORE};
               state_d                  = HDR0;
            end
         end
         HDR0: begin
            if (noc_ready_in) begin
               state_d = HDR1;
            end
         end
         HDR1: begin
            if (noc_ready_in) begin
               state_d = HDR2;
            end
         end
         HDR2: begin
            if (noc_ready_in) begin
               state_d = store_q ? DATA : IDLE;
            end
         end
         DATA: begin
            if (noc_ready_in) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Store size from the strobe; naturally aligned runs of 1/2/4 bytes
   // shrink the access, everything else goes out as a full 8B store.
   always_comb begin
      byte_off = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (strb_q[i]) begin
            byte_off = 3'(i);
         end
      end
      size_code = `MSG_DATA_SIZE_8B;
      sub_dword = 1'b0;
      case (strb_q)
         8'h01, 8'h02, 8'h04, 8'h08,
         8'h10, 8'h20, 8'h40, 8'h80: begin
            size_code = `MSG_DATA_SIZE_1B;
            sub_dword = 1'b1;
         end
         8'h03, 8'h0C, 8'h30, 8'hC0: begin
            size_code = `MSG_DATA_SIZE_2B;
            sub_dword = 1'b1;
         end
         8'h0F, 8'hF0: begin
            size_code = `MSG_DATA_SIZE_4B;
            sub_dword = 1'b1;
         end
         default: begin
            size_code = `MSG_DATA_SIZE_8B;
            sub_dword = 1'b0;
         end
      endcase
      if (!store_q) begin
         size_code = `MSG_DATA_SIZE_8B;
         sub_dword = 1'b0;
      end
   end

   assign flit_addr = sub_dword ? {addr_q[PA-1:3], byte_off} : addr_q;

   assign noc_valid_out = (state_q != IDLE);

   // Flits are built from held registers, so they stay stable
   // under back-pressure.
   always_comb begin
      noc_data_out = '0;
      case (state_q)
         HDR0: begin
            noc_data_out[`MSG_DST_CHIPID] = dest_chipid;
            noc_data_out[`MSG_DST_X]      = dest_xpos;
            noc_data_out[`MSG_DST_Y]      = dest_ypos;
            noc_data_out[`MSG_DST_FBITS]  = dest_fbits;
            noc_data_out[`MSG_LENGTH]     = store_q ? 8'd3 : 8'd2;
            noc_data_out[`MSG_TYPE]       = store_q ?
                                            `MSG_TYPE_NC_STORE_REQ :
                                            `MSG_TYPE_NC_LOAD_REQ;
            noc_data_out[`MSG_MSHRID]     = 8'd0;
         end
         HDR1: begin
            noc_data_out[`MSG_ADDR] =
               {{(`MSG_ADDR_WIDTH - PA){1'b0}}, flit_addr};
            noc_data_out[`MSG_DATA_SIZE] = size_code;
         end
         HDR2: begin
            noc_data_out[`MSG_SRC_CHIPID] = src_chipid;
            noc_data_out[`MSG_SRC_X]      = src_xpos;
            noc_data_out[`MSG_SRC_Y]      = src_ypos;
            noc_data_out[`MSG_SRC_FBITS]  = src_fbits;
         end
         DATA: begin
            // NoC payload is big-endian: AXI byte 0 goes to the top byte.
            for (int i = 0; i < 8; i++) begin
               noc_data_out[8*(7-i) +: 8] = data_q[8*i +: 8];
            end
         end
         default: begin
            noc_data_out = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         strb_q  <= '0;
         store_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         strb_q  <= strb_d;
         store_q <= store_d;
      end
   end

endmodule

// File: tb/tb_axilite_noc_request.sv
// tb_axilite_noc_request: randomized and directed bench for
// axilite_noc_request against a packet-level reference model.

module tb_axilite_noc_request;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] src_chipid, dest_chipid;
   logic [7:0]  src_xpos, src_ypos, dest_xpos, dest_ypos;
   logic [3:0]  src_fbits, dest_fbits;
   logic [63:0] s_axi_araddr, s_axi_awaddr, s_axi_wdata;
   logic        s_axi_arvalid, s_axi_arready;
   logic        s_axi_awvalid, s_axi_awready;
   logic [7:0]  s_axi_wstrb;
   logic        s_axi_wvalid, s_axi_wready;
   logic        noc_valid_out, noc_ready_in;
   logic [63:0] noc_data_out;
   logic [5:0]  transaction_type_wr_data;
   logic        transaction_type_wr, transaction_type_full;

   always #5 clk = ~clk;

   axilite_noc_request dut (
      .clk                      (clk),
      .rst                      (rst),
      .src_chipid               (src_chipid),
      .src_xpos                 (src_xpos),
      .src_ypos                 (src_ypos),
      .src_fbits                (src_fbits),
      .dest_chipid              (dest_chipid),
      .dest_xpos                (dest_xpos),
      .dest_ypos                (dest_ypos),
      .dest_fbits               (dest_fbits),
      .s_axi_araddr             (s_axi_araddr),
      .s_axi_arvalid            (s_axi_arvalid),
      .s_axi_arready            (s_axi_arready),
      .s_axi_awaddr             (s_axi_awaddr),
      .s_axi_awvalid            (s_axi_awvalid),
      .s_axi_awready            (s_axi_awready),
      .s_axi_wdata              (s_axi_wdata),
      .s_axi_wstrb              (s_axi_wstrb),
      .s_axi_wvalid             (s_axi_wvalid),
      .s_axi_wready             (s_axi_wready),
      .noc_valid_out            (noc_valid_out),
      .noc_data_out             (noc_data_out),
      .noc_ready_in             (noc_ready_in),
      .transaction_type_wr_data (transaction_type_wr_data),
      .transaction_type_wr      (transaction_type_wr),
      .transaction_type_full    (transaction_type_full)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model state
   logic [63:0] exp_q[$];
   bit          last_wr;
   logic [5:0]  last_desc;
   logic [63:0] pkt[4];
   int          pkt_n;
   int          grant_log[$];

   function automatic logic [63:0] f_hdr0(input bit st);
      return {dest_chipid, dest_xpos, dest_ypos, dest_fbits,
              st ? 8'd3 : 8'd2, st ? 8'd15 : 8'd14, 8'd0, 6'd0};
   endfunction

   function automatic logic [63:0] f_hdr1(input logic [39:0] a,
                                          input logic [2:0] sz);
      return {8'd0, a, sz, 13'd0};
   endfunction

   function automatic logic [63:0] f_hdr2();
      return {src_chipid, src_xpos, src_ypos, src_fbits, 30'd0};
   endfunction

   // A contiguous, naturally aligned run of 1, 2 or 4 bytes is a
   // sub-dword store at the run's first byte; anything else is 8B.
   function automatic void store_fields(input logic [7:0] s,
                                        input logic [39:0] a,
                                        output logic [39:0] ao,
                                        output logic [2:0] sz);
      int n;
      int lo;
      n  = $countones(s);
      lo = 0;
      for (int i = 7; i >= 0; i--) if (s[i]) lo = i;
      ao = a;
      sz = 3'd4;
      if ((n == 1 || n == 2 || n == 4) && (lo % n) == 0 &&
          s == 8'(((1 << n) - 1) << lo)) begin
         ao = {a[39:3], 3'(lo)};
         sz = (n == 1) ? 3'd1 : (n == 2) ? 3'd2 : 3'd3;
      end
   endfunction

   always @(negedge clk) begin : mon
      bit          busy, rd_el, wr_el, pk_rd, pk_wr;
      logic [39:0] ao;
      logic [2:0]  sz;
      logic [63:0] wd;
      if (rst) begin
         exp_q.delete();
         last_wr = 1'b1;
      end else begin
         busy  = (exp_q.size() != 0);
         rd_el = !busy && !transaction_type_full && s_axi_arvalid;
         wr_el = !busy && !transaction_type_full &&
                 s_axi_awvalid && s_axi_wvalid;
`ifdef AXILITE_NOC_REQ_RR_ARB_EN
         pk_rd = rd_el && (!wr_el || last_wr);
`else
         pk_rd = rd_el;
`endif
         pk_wr = wr_el && !pk_rd;
         chk("arready", 64'(s_axi_arready), 64'(pk_rd));
         chk("awready", 64'(s_axi_awready), 64'(pk_wr));
         chk("wready", 64'(s_axi_wready), 64'(pk_wr));
         chk("type_wr", 64'(transaction_type_wr), 64'(pk_rd || pk_wr));
         chk("noc_valid", 64'(noc_valid_out), 64'(busy));
         if (s_axi_arready) grant_log.push_back(0);
         if (s_axi_awready) grant_log.push_back(1);
         if (transaction_type_wr) last_desc = transaction_type_wr_data;
         if (busy) begin
            chk("flit", noc_data_out, exp_q[0]);
            if (noc_valid_out && noc_ready_in) begin
               if (pkt_n < 4) pkt[pkt_n] = noc_data_out;
               pkt_n++;
               void'(exp_q.pop_front());
            end
         end
         if (pk_rd) begin
            chk("rd_desc_live", 64'(transaction_type_wr_data),
                64'({3'b010, s_axi_araddr[3], 2'd1}));
            exp_q.push_back(f_hdr0(1'b0));
            exp_q.push_back(f_hdr1(s_axi_araddr[39:0], 3'd4));
            exp_q.push_back(f_hdr2());
            last_wr = 1'b0;
            pkt_n   = 0;
         end else if (pk_wr) begin
            chk("wr_desc_live", 64'(transaction_type_wr_data),
                64'(6'b100010));
            store_fields(s_axi_wstrb, s_axi_awaddr[39:0], ao, sz);
            wd = {<<8{s_axi_wdata}};
            exp_q.push_back(f_hdr0(1'b1));
            exp_q.push_back(f_hdr1(ao, sz));
            exp_q.push_back(f_hdr2());
            exp_q.push_back(wd);
            last_wr = 1'b1;
            pkt_n   = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accept(input string tag);
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (s_axi_arready || s_axi_awready) begin
            tick();
            return;
         end
      end
      chk({tag, "_accept_timeout"}, 64'd1, 64'd0);
   endtask

   task automatic wait_idle(input string tag, output int n);
      n = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         #1;
         if (exp_q.size() == 0) begin
            n = k;
            break;
         end
      end
      if (n == 0) chk({tag, "_idle_timeout"}, 64'd1, 64'd0);
      tick();
   endtask

   function automatic logic [7:0] rand_strb();
      int k;
      k = $urandom_range(0, 3);
      case ($urandom_range(0, 4))
         0: return 8'hFF;
         1: return 8'(1 << $urandom_range(0, 7));
         2: return 8'(8'h03 << (2 * k));
         3: return 8'(8'h0F << (4 * (k % 2)));
         default: return 8'($urandom);
      endcase
   endfunction

   task automatic idle_inputs();
      s_axi_arvalid         = 1'b0;
      s_axi_awvalid         = 1'b0;
      s_axi_wvalid          = 1'b0;
      transaction_type_full = 1'b0;
      noc_ready_in          = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nr;
      int nw;
      int exp_g;
      rst          = 1'b1;
      s_axi_araddr = '0;
      s_axi_awaddr = '0;
      s_axi_wdata  = '0;
      s_axi_wstrb  = '0;
      idle_inputs();
      noc_ready_in = 1'b0;
      src_chipid   = 14'($urandom);
      src_xpos     = 8'($urandom);
      src_ypos     = 8'($urandom);
      src_fbits    = 4'($urandom);
      dest_chipid  = 14'($urandom);
      dest_xpos    = 8'($urandom);
      dest_ypos    = 8'($urandom);
      dest_fbits   = 4'($urandom);
      repeat (3) tick();
      chk("rst_noc_valid", 64'(noc_valid_out), 64'd0);
      chk("rst_noc_data", noc_data_out, 64'd0);
      chk("rst_arready", 64'(s_axi_arready), 64'd0);
      chk("rst_awready", 64'(s_axi_awready), 64'd0);
      chk("rst_wready", 64'(s_axi_wready), 64'd0);
      chk("rst_type_wr", 64'(transaction_type_wr), 64'd0);
      rst          = 1'b0;
      noc_ready_in = 1'b1;
      tick();

      // Directed read
      s_axi_araddr  = 64'h0000_0000_8000_0008;
      s_axi_arvalid = 1'b1;
      wait_accept("read");
      s_axi_arvalid = 1'b0;
      chk("read_desc", 64'(last_desc), 64'(6'b010101));
      wait_idle("read", n);
      chk("read_cycles", 64'(n), 64'd3);
      chk("read_hdr0_len", 64'(pkt[0][29:22]), 64'd2);
      chk("read_hdr0_type", 64'(pkt[0][21:14]), 64'd14);
      chk("read_hdr1_addr", 64'(pkt[1][63:16]), 64'h8000_0008);
      chk("read_hdr1_size", 64'(pkt[1][15:13]), 64'd4);

      // Directed full write
      s_axi_awaddr  = 64'h100;
      s_axi_wdata   = 64'h0123_4567_89AB_CDEF;
      s_axi_wstrb   = 8'hFF;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      wait_accept("wfull");
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      chk("wfull_desc", 64'(last_desc), 64'(6'b100010));
      wait_idle("wfull", n);
      chk("wfull_cycles", 64'(n), 64'd4);
      chk("wfull_len", 64'(pkt[0][29:22]), 64'd3);
      chk("wfull_data", pkt[3], 64'hEFCD_AB89_6745_2301);

      // Directed partial write
      s_axi_wstrb   = 8'h30;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      wait_accept("wpart");
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
      wait_idle("wpart", n);
      chk("wpart_addr", 64'(pkt[1][63:16]), 64'h104);
      chk("wpart_size", 64'(pkt[1][15:13]), 64'd2);

      // Simultaneous AR and AW/W, four of each
      grant_log.delete();
      nr = 0;
      nw = 0;
      s_axi_arvalid = 1'b1;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      for (int g = 0; g < 8; g++) begin
         s_axi_araddr = {32'd0, $urandom};
         s_axi_awaddr = {32'd0, $urandom};
         s_axi_wdata  = {$urandom, $urandom};
         s_axi_wstrb  = rand_strb();
         wait_accept("arb");
         nr = 0;
         nw = 0;
         foreach (grant_log[i]) if (grant_log[i] == 0) nr++; else nw++;
         if (nr >= 4) s_axi_arvalid = 1'b0;
         if (nw >= 4) begin
            s_axi_awvalid = 1'b0;
            s_axi_wvalid  = 1'b0;
         end
      end
      idle_inputs();
      wait_idle("arb", n);
      chk("arb_count", 64'(grant_log.size()), 64'd8);
      for (int g = 0; g < 8 && g < grant_log.size(); g++) begin
`ifdef AXILITE_NOC_REQ_RR_ARB_EN
         exp_g = g % 2;
`else
         exp_g = (g >= 4) ? 1 : 0;
`endif
         chk($sformatf("arb_grant%0d", g), 64'(grant_log[g]), 64'(exp_g));
      end

      // Back-pressure during HDR1 with requests pending
      s_axi_araddr  = 64'h0000_0012_3456_7890;
      s_axi_arvalid = 1'b1;
      wait_accept("bp");
      s_axi_arvalid = 1'b0;
      tick();
      noc_ready_in  = 1'b0;
      s_axi_arvalid = 1'b1;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      repeat (5) tick();
      idle_inputs();
      wait_idle("bp", n);
      chk("bp_hdr1_addr", 64'(pkt[1][63:16]), 64'h12_3456_7890);

      // Type FIFO full blocks acceptance
      transaction_type_full = 1'b1;
      s_axi_arvalid         = 1'b1;
      s_axi_araddr          = 64'h40;
      repeat (3) tick();
      transaction_type_full = 1'b0;
      @(negedge clk);
      chk("full_release_arready", 64'(s_axi_arready), 64'd1);
      chk("full_release_push", 64'(transaction_type_wr), 64'd1);
      tick();
      s_axi_arvalid = 1'b0;
      wait_idle("full", n);

      // Random traffic
      for (int c = 0; c < 800; c++) begin
         s_axi_arvalid         = ($urandom_range(0, 2) == 0);
         s_axi_awvalid         = ($urandom_range(0, 1) == 0);
         s_axi_wvalid          = ($urandom_range(0, 3) != 0);
         transaction_type_full = ($urandom_range(0, 4) == 0);
         noc_ready_in          = ($urandom_range(0, 3) != 0);
         s_axi_araddr          = {$urandom, $urandom};
         s_axi_awaddr          = {$urandom, $urandom};
         s_axi_wdata           = {$urandom, $urandom};
         s_axi_wstrb           = rand_strb();
         tick();
      end
      idle_inputs();
      repeat (8) tick();
      chk("rand_drained", 64'(exp_q.size()), 64'd0);

      // Reset mid-packet
      s_axi_awaddr  = 64'h200;
      s_axi_wstrb   = 8'h0F;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      wait_accept("midrst");
      idle_inputs();
      tick();
      rst = 1'b1;
      #1;
      chk("midrst_valid", 64'(noc_valid_out), 64'd0);
      chk("midrst_data", noc_data_out, 64'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      s_axi_araddr  = 64'h0000_0000_0000_0ACC;
      s_axi_arvalid = 1'b1;
      wait_accept("postrst");
      s_axi_arvalid = 1'b0;
      wait_idle("postrst", n);
      chk("postrst_cycles", 64'(n), 64'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
